// File: rtl/falling_letter_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : falling_letter_scheduler
// Description : Game sequencer for the three-lane falling-letter renderer.
//               Spawns LFSR letters, drops them at a programmable rate,
//               retires them on a correct guess (score) or at the bottom
//               row (miss), and runs the IDLE/PLAY/OVER game state machine.
// Revision    : 1.0 - initial release
// ============================================================================

module falling_letter_scheduler #(
    parameter logic [23:0] DROP_DIV    = 24'd2_500_000,
    parameter logic [3:0]  SPAWN_STEPS = 4'd6,
    parameter logic [3:0]  MAX_MISS    = 4'd5,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] guess,
    input  logic       guess_valid,
    output logic [7:0] letter1,
    output logic [7:0] letter2,
    output logic [7:0] letter3,
    output logic [4:0] ypos1,
    output logic [4:0] ypos2,
    output logic [4:0] ypos3,
    output logic [7:0] score,
    output logic [3:0] misses,
    output logic       game_over
);

    localparam logic [4:0] c_ypos_hidden = 5'd31;
    localparam logic [4:0] c_ypos_last   = 5'd21;
    localparam logic [4:0] c_ypos_rows   = 5'd22;
    localparam logic [7:0] c_lfsr_taps   = 8'hB8;  // x^8+x^6+x^5+x^4+1
    localparam logic [7:0] c_score_max   = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_lfsr;
    logic [23:0] r_div_cnt, w_div_cnt_nxt;
    logic [3:0]  r_spawn_cnt, w_spawn_cnt_nxt;
    logic [7:0]  r_score, w_score_nxt;
    logic [3:0]  r_misses, w_misses_nxt;
    logic        r_game_over, w_game_over_nxt;
    logic [7:0]  r_letter [3];
    logic [7:0]  w_letter_nxt [3];
    logic [4:0]  r_ypos [3];
    logic [4:0]  w_ypos_nxt [3];

    logic [2:0]  w_active;
    logic [2:0]  w_hit;
    logic [2:0]  w_miss;
    logic [2:0]  w_spawn_sel;
    logic        w_hit_any;
    logic        w_idle_found;
    logic        w_step;
    logic        w_spawn;
    logic [1:0]  w_miss_n;
    logic [4:0]  w_miss_sum;
    logic [3:0]  w_miss_sat;
    logic        w_reach_max;

    // Free-running letter LFSR; shifts in every state so letters depend on start time
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & c_lfsr_taps)};
        end
    end

    // Per-lane evaluation: activity, guess priority, spawn target and miss count
    always_comb begin
        w_step       = (r_div_cnt == (DROP_DIV - 24'd1));
        w_active     = 3'b000;
        w_hit        = 3'b000;
        w_hit_any    = 1'b0;
        w_spawn_sel  = 3'b000;
        w_idle_found = 1'b0;
        w_miss       = 3'b000;
        w_miss_n     = 2'd0;
        for (int i = 0; i < 3; i++) begin
            w_active[i] = (r_ypos[i] < c_ypos_rows);
            // Only the lowest-index matching lane is retired by one guess
            if (!w_hit_any && guess_valid && w_active[i] && (r_letter[i] == guess)) begin
                w_hit[i]  = 1'b1;
                w_hit_any = 1'b1;
            end
            // Spawn target is chosen from lanes idle before this cycle's updates
            if (!w_idle_found && !w_active[i]) begin
                w_spawn_sel[i] = 1'b1;
                w_idle_found   = 1'b1;
            end
            // A guess on the bottom row beats the miss
            if (w_step && w_active[i] && !w_hit[i] && (r_ypos[i] == c_ypos_last)) begin
                w_miss[i] = 1'b1;
                w_miss_n  = w_miss_n + 2'd1;
            end
        end
        w_spawn     = w_step && (r_spawn_cnt == 4'd0) && w_idle_found;
        w_miss_sum  = {1'b0, r_misses} + {3'b000, w_miss_n};
        w_miss_sat  = (w_miss_sum >= {1'b0, MAX_MISS}) ? MAX_MISS : w_miss_sum[3:0];
        w_reach_max = (w_miss_n != 2'd0) && (w_miss_sum >= {1'b0, MAX_MISS});
    end

    // Next-state and datapath update for the game state machine
    always_comb begin
        w_state_nxt     = r_state;
        w_div_cnt_nxt   = r_div_cnt;
        w_spawn_cnt_nxt = r_spawn_cnt;
        w_score_nxt     = r_score;
        w_misses_nxt    = r_misses;
        w_game_over_nxt = r_game_over;
        for (int i = 0; i < 3; i++) begin
            w_letter_nxt[i] = r_letter[i];
            w_ypos_nxt[i]   = r_ypos[i];
        end

        case (r_state)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    w_state_nxt     = ST_PLAY;
                    w_score_nxt     = 8'd0;
                    w_misses_nxt    = 4'd0;
                    w_div_cnt_nxt   = 24'd0;
                    w_spawn_cnt_nxt = 4'd0;
                    w_game_over_nxt = 1'b0;
                end
            end

            ST_PLAY: begin
                w_div_cnt_nxt = w_step ? 24'd0 : (r_div_cnt + 24'd1);
                if (w_step) begin
                    w_spawn_cnt_nxt = ((r_spawn_cnt + 4'd1) == SPAWN_STEPS) ? 4'd0
                                                                            : (r_spawn_cnt + 4'd1);
                end
                if (w_hit_any && (r_score != c_score_max)) begin
                    w_score_nxt = r_score + 8'd1;
                end
                for (int i = 0; i < 3; i++) begin
                    if (w_hit[i]) begin
                        w_ypos_nxt[i] = c_ypos_hidden;
                    end else if (w_step && w_active[i]) begin
                        w_ypos_nxt[i] = w_miss[i] ? c_ypos_hidden : (r_ypos[i] + 5'd1);
                    end
                    if (w_spawn && w_spawn_sel[i]) begin
                        w_ypos_nxt[i]   = 5'd0;
                        w_letter_nxt[i] = r_lfsr;
                    end
                end
                if (w_miss_n != 2'd0) begin
                    w_misses_nxt = w_miss_sat;
                end
                // Game ends in the cycle the miss total reaches the limit; lanes blank
                if (w_reach_max) begin
                    w_state_nxt     = ST_OVER;
                    w_game_over_nxt = 1'b1;
                    for (int i = 0; i < 3; i++) begin
                        w_ypos_nxt[i] = c_ypos_hidden;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_div_cnt   <= 24'd0;
            r_spawn_cnt <= 4'd0;
            r_score     <= 8'd0;
            r_misses    <= 4'd0;
            r_game_over <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_letter[i] <= 8'd0;
                r_ypos[i]   <= c_ypos_hidden;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_div_cnt   <= w_div_cnt_nxt;
            r_spawn_cnt <= w_spawn_cnt_nxt;
            r_score     <= w_score_nxt;
            r_misses    <= w_misses_nxt;
            r_game_over <= w_game_over_nxt;
            for (int i = 0; i < 3; i++) begin
                r_letter[i] <= w_letter_nxt[i];
                r_ypos[i]   <= w_ypos_nxt[i];
            end
        end
    end

    assign letter1   = r_letter[0];
    assign letter2   = r_letter[1];
    assign letter3   = r_letter[2];
    assign ypos1     = r_ypos[0];
    assign ypos2     = r_ypos[1];
    assign ypos3     = r_ypos[2];
    assign score     = r_score;
    assign misses    = r_misses;
    assign game_over = r_game_over;

endmodule

`default_nettype wire

// File: tb/tb_falling_letter_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_falling_letter_scheduler
// Description : Self-checking bench for falling_letter_scheduler. Instance A
//               uses the small game parameters; instance B uses a 255-cycle
//               spawn spacing so two lanes receive the same letter.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_falling_letter_scheduler;

    logic clock = 1'b0;
    logic reset_n;
    logic start0, gv0, start1, gv1;
    logic [7:0] guess0, guess1;

    logic [7:0] l1a, l2a, l3a, l1b, l2b, l3b;
    logic [4:0] y1a, y2a, y3a, y1b, y2b, y3b;
    logic [7:0] sca, scb;
    logic [3:0] msa, msb;
    logic       goa, gob;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    falling_letter_scheduler #(
        .DROP_DIV(24'd4), .SPAWN_STEPS(4'd2), .MAX_MISS(4'd2), .LFSR_SEED(8'hA5)
    ) dut_a (
        .clock(clock), .reset_n(reset_n), .start(start0), .guess(guess0),
        .guess_valid(gv0), .letter1(l1a), .letter2(l2a), .letter3(l3a),
        .ypos1(y1a), .ypos2(y2a), .ypos3(y3a), .score(sca), .misses(msa),
        .game_over(goa)
    );

    falling_letter_scheduler #(
        .DROP_DIV(24'd51), .SPAWN_STEPS(4'd5), .MAX_MISS(4'd5), .LFSR_SEED(8'hA5)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start1), .guess(guess1),
        .guess_valid(gv1), .letter1(l1b), .letter2(l2b), .letter3(l3b),
        .ypos1(y1b), .ypos2(y2b), .ypos3(y3b), .score(scb), .misses(msb),
        .game_over(gob)
    );

    // ---------------- reference model (game rules, per instance) -----------
    int p_dd [2] = '{4, 51};
    int p_ss [2] = '{2, 5};
    int p_mm [2] = '{2, 5};
    int m_phase [2];          // 0 idle, 1 play, 2 over
    int m_cyc [2];            // cycles spent in the current game
    int m_steps [2];          // descent steps taken in the current game
    int m_lfsr [2];
    int m_score [2];
    int m_misses [2];
    int m_letter [2][3];
    int m_ypos [2][3];

    function automatic int lfsr_next(input int v);
        logic [7:0] s;
        s = v[7:0];
        return int'({s[6:0], ^(s & 8'hB8)});
    endfunction

    task automatic model_reset(input int k);
        m_phase[k] = 0; m_cyc[k] = 0; m_steps[k] = 0; m_lfsr[k] = 'hA5;
        m_score[k] = 0; m_misses[k] = 0;
        for (int i = 0; i < 3; i++) begin
            m_letter[k][i] = 0;
            m_ypos[k][i]   = 31;
        end
    endtask

    task automatic model_tick(input int k, input logic st, input logic gv, input logic [7:0] g);
        int  ny [3];
        int  nl [3];
        int  hit, nm, tgt;
        bit  step;
        for (int i = 0; i < 3; i++) begin
            ny[i] = m_ypos[k][i];
            nl[i] = m_letter[k][i];
        end
        if (m_phase[k] == 1) begin
            step = ((m_cyc[k] % p_dd[k]) == p_dd[k] - 1);
            hit  = -1;
            if (gv) begin
                for (int i = 0; i < 3; i++)
                    if (hit < 0 && m_ypos[k][i] < 22 && m_letter[k][i] == int'(g)) hit = i;
            end
            if (hit >= 0) begin
                ny[hit] = 31;
                if (m_score[k] < 255) m_score[k]++;
            end
            nm = 0;
            if (step) begin
                for (int i = 0; i < 3; i++) begin
                    if (i != hit && m_ypos[k][i] < 22) begin
                        if (m_ypos[k][i] == 21) begin ny[i] = 31; nm++; end
                        else ny[i] = m_ypos[k][i] + 1;
                    end
                end
                if (m_steps[k] % p_ss[k] == 0) begin
                    tgt = -1;
                    for (int i = 0; i < 3; i++)
                        if (tgt < 0 && m_ypos[k][i] >= 22) tgt = i;
                    if (tgt >= 0) begin ny[tgt] = 0; nl[tgt] = m_lfsr[k]; end
                end
                m_steps[k]++;
            end
            m_cyc[k]++;
            if (nm > 0) begin
                m_misses[k] = (m_misses[k] + nm > p_mm[k]) ? p_mm[k] : m_misses[k] + nm;
                if (m_misses[k] == p_mm[k]) begin
                    m_phase[k] = 2;
                    for (int i = 0; i < 3; i++) ny[i] = 31;
                end
            end
        end else if (st) begin
            m_phase[k] = 1; m_score[k] = 0; m_misses[k] = 0; m_cyc[k] = 0; m_steps[k] = 0;
        end
        for (int i = 0; i < 3; i++) begin
            m_ypos[k][i]   = ny[i];
            m_letter[k][i] = nl[i];
        end
        m_lfsr[k] = lfsr_next(m_lfsr[k]);
    endtask

    task automatic check_dut(input int k, input logic [51:0] act);
        logic [51:0] exp;
        exp = {8'(m_letter[k][0]), 8'(m_letter[k][1]), 8'(m_letter[k][2]),
               5'(m_ypos[k][0]), 5'(m_ypos[k][1]), 5'(m_ypos[k][2]),
               8'(m_score[k]), 4'(m_misses[k]), (m_phase[k] == 2)};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL model_cmp inst%0d t=%0t got=%h exp=%h", k, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_tick(0, start0, gv0, guess0);
        model_tick(1, start1, gv1, guess1);
        @(negedge clock);
        check_dut(0, {l1a, l2a, l3a, y1a, y2a, y3a, sca, msa, goa});
        check_dut(1, {l1b, l2b, l3b, y1b, y2b, y3b, scb, msb, gob});
    endtask

    task automatic check_const(input string name, input logic [51:0] act, input logic [51:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table (instance A) -------------------
    typedef struct {
        bit         st;
        bit         gv;
        int         gsel;     // -1: use graw, else model letter of that lane
        logic [7:0] graw;
        int         cyc;
        int         y1, y2, y3, sc, ms;
        bit         go;
    } vec_t;

    vec_t vecs [15];

    task automatic set_vec(input int idx, input bit st, input bit gv, input int gsel,
                           input logic [7:0] graw, input int cyc, input int y1,
                           input int y2, input int y3, input int sc, input int ms,
                           input bit go);
        vecs[idx].st = st;   vecs[idx].gv = gv;   vecs[idx].gsel = gsel;
        vecs[idx].graw = graw; vecs[idx].cyc = cyc;
        vecs[idx].y1 = y1;   vecs[idx].y2 = y2;   vecs[idx].y3 = y3;
        vecs[idx].sc = sc;   vecs[idx].ms = ms;   vecs[idx].go = go;
    endtask

    localparam logic [51:0] c_reset_vals = {24'h0, 15'h7FFF, 8'h0, 4'h0, 1'b0};

    initial begin
        int waited;
        // Play-cycle comments: step k lands on play cycle 4k, spawn on odd steps
        set_vec(0,  1, 0, -1, 8'h00, 1,  31, 31, 31, 0, 0, 0);  // enter PLAY
        set_vec(1,  0, 0, -1, 8'h00, 3,  31, 31, 31, 0, 0, 0);  // before step 1
        set_vec(2,  0, 0, -1, 8'h00, 1,   0, 31, 31, 0, 0, 0);  // step 1: lane1 spawns
        set_vec(3,  0, 0, -1, 8'h00, 8,   2,  0, 31, 0, 0, 0);  // step 3: lane2 spawns
        set_vec(4,  0, 0, -1, 8'h00, 12,  5,  3,  1, 0, 0, 0);  // step 6
        set_vec(5,  0, 1,  0, 8'h00, 1,  31,  3,  1, 1, 0, 0);  // hit lane1 at row 5
        set_vec(6,  0, 1, -1, 8'h00, 1,  31,  3,  1, 1, 0, 0);  // no-match guess
        set_vec(7,  0, 0, -1, 8'h00, 2,   0,  4,  2, 1, 0, 0);  // step 7: lane1 respawns
        set_vec(8,  0, 0, -1, 8'h00, 71, 17, 21, 19, 1, 0, 0);  // step 24: lane2 on row 21
        set_vec(9,  0, 1,  1, 8'h00, 1,  18, 31, 20, 2, 0, 0);  // guess wins over miss
        set_vec(10, 0, 0, -1, 8'h00, 8,  20,  0, 31, 2, 1, 0);  // lane3 miss, lane2 spawns
        set_vec(11, 0, 0, -1, 8'h00, 8,  31, 31, 31, 2, 2, 1);  // lane1 miss -> OVER
        set_vec(12, 0, 0, -1, 8'h00, 5,  31, 31, 31, 2, 2, 1);  // OVER holds
        set_vec(13, 1, 0, -1, 8'h00, 1,  31, 31, 31, 0, 0, 0);  // restart clears
        set_vec(14, 0, 0, -1, 8'h00, 10,  1, 31, 31, 0, 0, 0);  // two steps in

        reset_n = 1'b0;
        start0 = 1'b0; gv0 = 1'b0; guess0 = 8'h00;
        start1 = 1'b0; gv1 = 1'b0; guess1 = 8'h00;
        model_reset(0);
        model_reset(1);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        repeat (20) tick();
        check_const("idle_after_reset", {l1a, l2a, l3a, y1a, y2a, y3a, sca, msa, goa}, c_reset_vals);

        for (int v = 0; v < 15; v++) begin
            start0 = vecs[v].st;
            gv0    = vecs[v].gv;
            guess0 = (vecs[v].gsel < 0) ? vecs[v].graw : 8'(m_letter[0][vecs[v].gsel]);
            repeat (vecs[v].cyc) tick();
            start0 = 1'b0;
            gv0    = 1'b0;
            n_checks++;
            if ({y1a, y2a, y3a, sca, msa, goa} !==
                {5'(vecs[v].y1), 5'(vecs[v].y2), 5'(vecs[v].y3), 8'(vecs[v].sc),
                 4'(vecs[v].ms), vecs[v].go}) begin
                n_fail++;
                $display("FAIL vec%0d got y=%0d,%0d,%0d sc=%0d ms=%0d go=%0d exp y=%0d,%0d,%0d sc=%0d ms=%0d go=%0d",
                         v, y1a, y2a, y3a, sca, msa, goa, vecs[v].y1, vecs[v].y2, vecs[v].y3,
                         vecs[v].sc, vecs[v].ms, vecs[v].go);
            end
        end

        // Asynchronous reset in the middle of a game
        #1 reset_n = 1'b0;
        #1;
        check_const("async_reset_a", {l1a, l2a, l3a, y1a, y2a, y3a, sca, msa, goa}, c_reset_vals);
        check_const("async_reset_b", {l1b, l2b, l3b, y1b, y2b, y3b, scb, msb, gob}, c_reset_vals);
        model_reset(0);
        model_reset(1);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Instance B: lanes 1 and 2 spawn 255 cycles apart and carry the same letter
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        waited = 0;
        while (m_steps[1] < 6 && waited < 400) begin
            tick();
            waited++;
        end
        n_checks++;
        if (waited >= 400) begin
            n_fail++;
            $display("FAIL equal_letter_wait got=timeout exp=6 steps");
        end
        guess1 = 8'(m_letter[1][0]);
        gv1    = 1'b1;
        tick();
        gv1    = 1'b0;
        check_const("equal_letter_lowest", {27'h0, y1b, y2b, scb, 7'h0}, {27'h0, 5'd31, 5'd0, 8'd1, 7'h0});

        // Randomized play on instance A against the model
        for (int n = 0; n < 3000; n++) begin
            int sel;
            start0 = ($urandom_range(0, 15) == 0);
            gv0    = ($urandom_range(0, 3) == 0);
            sel    = $urandom_range(0, 3);
            guess0 = (sel < 3) ? 8'(m_letter[0][sel]) : 8'($urandom);
            tick();
        end
        start0 = 1'b0;
        gv0    = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/falling_letter_scheduler.md
Name: falling_letter_scheduler

Overview:
- Game sequencer for the three-lane falling-letter framebuffer renderer. Drives `letter1..3` / `ypos1..3` into the renderer each frame.
- Spawns pseudo-random letters, steps them down at a programmable rate, and retires them on a correct guess (score) or on reaching the bottom row (miss).
- Owns the IDLE/PLAY/OVER game state machine, with score and miss counters for the status display.

Parameters:
- DROP_DIV, 24'd2_500_000: clocks per descent step (must be ≥2).
- SPAWN_STEPS, 4'd6: descent steps between spawn attempts (must be ≥1).
- MAX_MISS, 4'd5: miss count that ends the game.
- LFSR_SEED, 8'hA5: letter LFSR reset value (nonzero).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  level; sampled in IDLE/OVER to begin a new game.
- guess  in  8  player letter code.
- guess_valid  in  1  one-cycle strobe qualifying `guess`.
- letter1, letter2, letter3  out  8  letter code per lane (registered).
- ypos1, ypos2, ypos3  out  5  row per lane; 0..21 visible, 5'd31 = hidden/idle (registered).
- score  out  8  correct guesses, saturating at 255.
- misses  out  4  letters lost, saturating at MAX_MISS.
- game_over  out  1  high in OVER.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, all letters=0, all ypos=31, score=0, misses=0, game_over=0, div_cnt=0, spawn_cnt=0, lfsr=LFSR_SEED.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1; shifts every clock in all states, so seeding is start-time dependent.
- Lane active ⇔ ypos<22. All outputs change only on clock edges.
- IDLE: lanes hidden, counters frozen. start=1 → PLAY next cycle; score, misses, div_cnt, spawn_cnt cleared.
- PLAY, prescaler:
  - div_cnt increments each cycle.
  - step=1 in the cycle div_cnt==DROP_DIV-1; div_cnt wraps to 0 that cycle.
  - First step occurs DROP_DIV cycles after entering PLAY.
- PLAY, guess (evaluated every cycle guess_valid=1):
  - Compared against the letters of active lanes.
  - Lowest-index matching lane: ypos←31; score+1 (saturating).
  - Only one lane is cleared per guess.
  - No match: no effect.
- PLAY, step:
  - Each active lane not cleared by a guess this cycle: if ypos==21, ypos←31 and count a miss; else ypos+1.
  - Misses from all lanes in one step are summed; misses←min(misses+n, MAX_MISS).
- PLAY, spawn (on step):
  - Occurs if spawn_cnt==0; spawn_cnt←(spawn_cnt+1) mod SPAWN_STEPS on every step.
  - Target is the lowest-index lane that was idle at the start of the cycle: letter←lfsr, ypos←0.
  - A lane freed this same cycle (by guess or miss) is not eligible.
  - No idle lane: spawn skipped, spawn_cnt still advances.
- Simultaneous guess + step on the same lane: guess wins. Lane cleared, scored, no miss even at ypos 21.
- PLAY→OVER: in the cycle the misses update reaches MAX_MISS. Next cycle: state=OVER, game_over=1, all ypos=31; score/misses hold. A guess in that same cycle still scores.
- start in PLAY: ignored.
- OVER: counters frozen; start=1 → PLAY with the same clears as from IDLE, and game_over←0.
- Reset mid-game: immediate return to reset values regardless of state.

Test Plan (DROP_DIV=4, SPAWN_STEPS=2, MAX_MISS=2, LFSR_SEED=8'hA5):
- Reset then idle 20 cycles → ypos1..3=31, score=0, misses=0, game_over=0; start held → state PLAY one cycle after start sampled.
- Start, no guesses → lane1 spawns (ypos1=0, letter1=LFSR value at that edge) 4 cycles into PLAY. Lane2 spawns 8 steps later? No: lane2 spawns at step 3 (spawn_cnt=0 again). ypos1 reaches 21 at step 22; miss at step 23 (cycle 92 of PLAY): ypos1=31, misses=1.
- Guess letter1 while ypos1=5 → next edge ypos1=31, score=1; wrong guess 8'h00 (no match) → score unchanged.
- Guess matching lane1 in the exact step cycle with ypos1=21 → score+1, misses unchanged.
- Two lanes with equal letters, one guess → only lower-index lane cleared, score+1.
- Let misses hit 2 → game_over=1 next cycle, all ypos=31, score held; assert reset_n=0 mid-PLAY → all outputs at reset values asynchronously; start from OVER → score=0, misses=0, game_over=0.
